hazard_forward_unit: RTL and testbench



---
 rtl/hazard_forward_unit.sv | 114 +++++++++++
 tb/tb_hazard_forward_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Load-use stall, branch/jump flush and EX operand forwarding control for the
// ID/EX stage, with private shadows of the EX/MEM and MEM/WB write-back fields.
module hazard_forward_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic [4:0]       IDEX_rs_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic [4:0]       IDEX_rd_i,
  input  logic             IDEX_MemRead_i,
  input  logic             IDEX_RegWrite_i,
  input  logic             Branch_taken_i,
  input  logic             Jump_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IDEX_bubble_o,
  output logic             IFID_flush_o,
  output logic [1:0]       ForwardA_o,
  output logic [1:0]       ForwardB_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             exmem_rw_q, memwb_rw_q;
  logic [4:0]       exmem_rd_q, memwb_rd_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu, redirect, stall_evt, flush_evt;

  assign lu = IDEX_MemRead_i && (IDEX_rd_i != 5'd0) &&
              ((IDEX_rd_i == IFID_rs_i) || (IDEX_rd_i == IFID_rt_i));
  assign redirect = Branch_taken_i || Jump_i;

  // A load-use stall takes priority over a redirect: the branch operands are
  // not valid yet, so the branch re-resolves in the following (STALL) cycle.
  always_comb begin
    state_d       = RUN;
    PCWrite_o     = 1'b1;
    IFIDWrite_o   = 1'b1;
    IDEX_bubble_o = 1'b0;
    IFID_flush_o  = 1'b0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;
    case (state_q)
      RUN: begin
        if (lu) begin
          PCWrite_o     = 1'b0;
          IFIDWrite_o   = 1'b0;
          IDEX_bubble_o = 1'b1;
          stall_evt     = 1'b1;
          state_d       = STALL;
        end else if (redirect) begin
          IFID_flush_o = 1'b1;
          flush_evt    = 1'b1;
        end
      end
      STALL: begin
        if (redirect) begin
          IFID_flush_o = 1'b1;
          flush_evt    = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign stall_cnt_d = (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) ?
                       flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  // Shadows advance every cycle; a bubble already carries RegWrite=0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      exmem_rw_q  <= 1'b0;
      exmem_rd_q  <= 5'd0;
      memwb_rw_q  <= 1'b0;
      memwb_rd_q  <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      exmem_rw_q  <= IDEX_RegWrite_i;
      exmem_rd_q  <= IDEX_rd_i;
      memwb_rw_q  <= exmem_rw_q;
      memwb_rd_q  <= exmem_rd_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       em_rw,
                                         input logic [4:0] em_rd,
                                         input logic       mw_rw,
                                         input logic [4:0] mw_rd);
    if (em_rw && (em_rd != 5'd0) && (em_rd == src))      return 2'b10;
    else if (mw_rw && (mw_rd != 5'd0) && (mw_rd == src)) return 2'b01;
    else                                                 return 2'b00;
  endfunction

  assign ForwardA_o  = fwd_sel(IDEX_rs_i, exmem_rw_q, exmem_rd_q, memwb_rw_q, memwb_rd_q);
  assign ForwardB_o  = fwd_sel(IDEX_rt_i, exmem_rw_q, exmem_rd_q, memwb_rw_q, memwb_rd_q);
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a history-based model checked every
// cycle, plus literal expectations at key points; a second instance has CNT_W=2.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rs = '0, idex_rt = '0, idex_rd = '0;
  logic       memread = 1'b0, regwrite = 1'b0, br = 1'b0, jmp = 1'b0;

  logic        pcw, ifidw, bub, fl;
  logic [1:0]  fa, fb;
  logic [15:0] scnt, fcnt;
  logic        pcw2, ifidw2, bub2, fl2;
  logic [1:0]  fa2, fb2;
  logic [1:0]  scnt2, fcnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_rs_i(ifid_rs), .IFID_rt_i(ifid_rt),
    .IDEX_rs_i(idex_rs), .IDEX_rt_i(idex_rt), .IDEX_rd_i(idex_rd),
    .IDEX_MemRead_i(memread), .IDEX_RegWrite_i(regwrite),
    .Branch_taken_i(br), .Jump_i(jmp),
    .PCWrite_o(pcw), .IFIDWrite_o(ifidw), .IDEX_bubble_o(bub), .IFID_flush_o(fl),
    .ForwardA_o(fa), .ForwardB_o(fb), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  hazard_forward_unit #(.CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .IFID_rs_i(ifid_rs), .IFID_rt_i(ifid_rt),
    .IDEX_rs_i(idex_rs), .IDEX_rt_i(idex_rt), .IDEX_rd_i(idex_rd),
    .IDEX_MemRead_i(memread), .IDEX_RegWrite_i(regwrite),
    .Branch_taken_i(br), .Jump_i(jmp),
    .PCWrite_o(pcw2), .IFIDWrite_o(ifidw2), .IDEX_bubble_o(bub2), .IFID_flush_o(fl2),
    .ForwardA_o(fa2), .ForwardB_o(fb2), .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2)
  );

  // ---------------- model: write-back history of the last two EX instructions
  typedef struct {
    logic       rw;
    logic [4:0] rd;
  } wb_t;

  wb_t hist[$];
  bit  stalled_last = 1'b0;
  int  stall_events = 0;
  int  flush_events = 0;

  function automatic bit m_stall();
    bit lu;
    lu = memread && (idex_rd != 0) && (idex_rd == ifid_rs || idex_rd == ifid_rt);
    return lu && !stalled_last;
  endfunction

  function automatic bit m_flush();
    return !m_stall() && (br || jmp);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    int n;
    n = hist.size();
    if (n >= 1 && hist[n-1].rw && hist[n-1].rd != 0 && hist[n-1].rd == src) return 2'b10;
    if (n >= 2 && hist[n-2].rw && hist[n-2].rd != 0 && hist[n-2].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      stalled_last = 1'b0;
      stall_events = 0;
      flush_events = 0;
    end else begin
      bit s, f;
      wb_t e;
      s = m_stall();
      f = m_flush();
      if (s) stall_events++;
      if (f) flush_events++;
      stalled_last = s;
      e.rw = regwrite;
      e.rd = idex_rd;
      hist.push_back(e);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare
  always @(negedge clk) begin
    if (!rst) begin
      check("m_pcwrite",   pcw,   !m_stall());
      check("m_ifidwrite", ifidw, !m_stall());
      check("m_bubble",    bub,   m_stall());
      check("m_flush",     fl,    m_flush());
      check("m_fwdA",      fa,    m_fwd(idex_rs));
      check("m_fwdB",      fb,    m_fwd(idex_rt));
      check("m_stall_cnt", scnt,  sat(stall_events, 65535));
      check("m_flush_cnt", fcnt,  sat(flush_events, 65535));
      check("m2_bubble",   bub2,  m_stall());
      check("m2_flush",    fl2,   m_flush());
      check("m2_stall_cnt", scnt2, sat(stall_events, 3));
      check("m2_flush_cnt", fcnt2, sat(flush_events, 3));
    end
  end

  // ---------------- driver
  task automatic vec(input logic [4:0] i_ifid_rs, input logic [4:0] i_ifid_rt,
                     input logic [4:0] i_idex_rs, input logic [4:0] i_idex_rt,
                     input logic [4:0] i_idex_rd, input logic i_mr, input logic i_rw,
                     input logic i_br, input logic i_j);
    @(posedge clk);
    #2;
    ifid_rs = i_ifid_rs; ifid_rt = i_ifid_rt;
    idex_rs = i_idex_rs; idex_rt = i_idex_rt; idex_rd = i_idex_rd;
    memread = i_mr; regwrite = i_rw; br = i_br; jmp = i_j;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // reset / idle
    idle();
    check("rst_pcwrite", pcw, 1);
    check("rst_ifidwrite", ifidw, 1);
    check("rst_bubble", bub, 0);
    check("rst_flush", fl, 0);
    check("rst_fwdA", fa, 0);
    check("rst_stall_cnt", scnt, 0);

    // branch then jump flush
    vec(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("br_flush", fl, 1);
    check("br_pcwrite", pcw, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("jmp_flush", fl, 1);
    check("flush_cnt_1", fcnt, 1);
    idle();
    check("flush_cnt_2", fcnt, 2);

    // load-use: stall once, then STALL ignores the hazard
    vec(8, 0, 0, 0, 8, 1, 1, 0, 0);
    check("lu_pcwrite", pcw, 0);
    check("lu_ifidwrite", ifidw, 0);
    check("lu_bubble", bub, 1);
    vec(8, 0, 0, 0, 8, 1, 1, 0, 0);
    check("lu2_bubble", bub, 0);
    check("lu2_pcwrite", pcw, 1);
    check("stall_cnt_1", scnt, 1);
    vec(0, 8, 0, 0, 0, 1, 0, 0, 0);
    check("lu_rd0_bubble", bub, 0);
    idle();
    idle();

    // forwarding priority
    vec(0, 0, 0, 0, 5, 0, 1, 0, 0);
    vec(0, 0, 0, 0, 5, 0, 1, 0, 0);
    vec(0, 0, 5, 0, 0, 0, 0, 0, 0);
    check("fwd_exmem", fa, 2'b10);
    vec(0, 0, 5, 5, 0, 0, 0, 0, 0);
    check("fwd_memwb", fa, 2'b01);
    check("fwd_memwb_B", fb, 2'b01);
    vec(0, 0, 0, 0, 6, 0, 1, 0, 0);
    vec(0, 0, 0, 0, 7, 0, 1, 0, 0);
    vec(0, 0, 7, 6, 0, 0, 0, 0, 0);
    check("fwd_mix_A", fa, 2'b10);
    check("fwd_mix_B", fb, 2'b01);
    vec(0, 0, 0, 0, 0, 0, 1, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 1, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("fwd_r0", fa, 2'b00);
    idle();

    // load-use coincident with branch, then branch re-resolves in STALL
    vec(8, 0, 0, 0, 8, 1, 1, 1, 0);
    check("lubr_bubble", bub, 1);
    check("lubr_flush", fl, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("stbr_flush", fl, 1);
    idle();
    check("flush_cnt_3", fcnt, 3);
    check("stall_cnt_2", scnt, 2);

    // five more stalls: wide counter 7, narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      vec(0, 9, 0, 0, 9, 1, 1, 0, 0);
      idle();
    end
    check("sat_wide", scnt, 7);
    check("sat_narrow", scnt2, 3);

    // asynchronous reset while in STALL
    vec(8, 0, 0, 0, 8, 1, 1, 0, 0);
    vec(0, 0, 8, 0, 0, 0, 0, 0, 0);
    check("pre_rst_fwdA", fa, 2'b10);
    #1 rst = 1'b1;
    #1;
    check("arst_pcwrite", pcw, 1);
    check("arst_bubble", bub, 0);
    check("arst_fwdA", fa, 0);
    check("arst_stall_cnt", scnt, 0);
    check("arst_flush_cnt", fcnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // forwarding resumes after the history refills
    vec(0, 0, 3, 0, 3, 0, 1, 0, 0);
    check("post_rst_fwd_empty", fa, 0);
    vec(0, 0, 3, 0, 0, 0, 0, 0, 0);
    check("post_rst_fwd", fa, 2'b10);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
